// File: rtl/esteira_controle_if.sv
// Signal bundle between the line sequencer (sensor-latch/divider side) and the
// conveyor/filling-station controller.
interface esteira_controle_if;
  logic       tick;
  logic       bottle_p;
  logic       tank_low;
  logic       start;
  logic       stop;
  logic       fault_clr;
  logic       motor_on;
  logic       valve_open;
  logic       capper_on;
  logic       batch_done;
  logic       alarm;
  logic [7:0] bottle_count;
  logic [2:0] state;

  modport master (
    output tick, bottle_p, tank_low, start, stop, fault_clr,
    input  motor_on, valve_open, capper_on, batch_done, alarm, bottle_count, state
  );

  modport slave (
    input  tick, bottle_p, tank_low, start, stop, fault_clr,
    output motor_on, valve_open, capper_on, batch_done, alarm, bottle_count, state
  );
endinterface

// File: rtl/esteira_controle.sv
// Conveyor / filling-station controller for the wine-bottle line.
// Runs the belt until a bottle arrives, fills it for FILL_TICKS slow ticks,
// caps it for CAP_TICKS ticks, counts it, and stops at DONE after BATCH
// bottles. Tank-low during filling or a belt with no bottle for
// TIMEOUT_TICKS ticks latches FAULT until acknowledged.
module esteira_controle #(
  parameter int FILL_TICKS    = 4,
  parameter int CAP_TICKS     = 2,
  parameter int BATCH         = 3,
  parameter int TIMEOUT_TICKS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  esteira_controle_if.slave    bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_CAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  // Counter value seen on the clk carrying the Nth tick after state entry.
  localparam logic [7:0] L_FILL_LAST = 8'(FILL_TICKS - 1);
  localparam logic [7:0] L_CAP_LAST  = 8'(CAP_TICKS - 1);
  localparam logic [7:0] L_TMO_LAST  = 8'(TIMEOUT_TICKS - 1);
  localparam logic [7:0] L_BATCH     = 8'(BATCH);

  logic [2:0] r_state;
  logic [7:0] r_tick_cnt;
  logic [7:0] r_count;
  logic       r_prev;

  logic [2:0] w_next;
  logic [7:0] w_count_next;
  logic [7:0] w_count_inc;
  logic       w_edge;
  logic       w_tick_last_fill;
  logic       w_tick_last_cap;
  logic       w_tick_last_tmo;

  assign w_edge           = bus.bottle_p & ~r_prev;
  assign w_count_inc      = r_count + 8'd1;
  assign w_tick_last_fill = bus.tick && (r_tick_cnt == L_FILL_LAST);
  assign w_tick_last_cap  = bus.tick && (r_tick_cnt == L_CAP_LAST);
  assign w_tick_last_tmo  = bus.tick && (r_tick_cnt == L_TMO_LAST);

  // Next-state and batch-count decision; stop outranks tank_low, which
  // outranks the timed/edge events.
  always_comb begin
    w_next       = r_state;
    w_count_next = r_count;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_RUN;
      end
      S_RUN: begin
        if (bus.stop)                w_next = S_IDLE;
        else if (w_edge)             w_next = S_FILL;
        else if (w_tick_last_tmo)    w_next = S_FAULT;
      end
      S_FILL: begin
        if (bus.stop)                w_next = S_IDLE;
        else if (bus.tank_low)       w_next = S_FAULT;
        else if (w_tick_last_fill)   w_next = S_CAP;
      end
      S_CAP: begin
        if (bus.stop) begin
          w_next = S_IDLE;
        end else if (w_tick_last_cap) begin
          w_count_next = w_count_inc;
          w_next       = (w_count_inc == L_BATCH) ? S_DONE : S_RUN;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          w_next       = S_RUN;
          w_count_next = 8'd0;
        end
      end
      S_FAULT: begin
        if (bus.fault_clr && !bus.tank_low) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, batch count and sensor history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_count <= 8'd0;
      r_prev  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_count <= w_count_next;
      r_prev  <= bus.bottle_p;
    end
  end

  // Slow-tick counter: restarts on every state change, advances on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= 8'd0;
    end else if (w_next != r_state) begin
      r_tick_cnt <= 8'd0;
    end else if (bus.tick) begin
      r_tick_cnt <= r_tick_cnt + 8'd1;
    end
  end

  assign bus.motor_on     = (r_state == S_RUN);
  assign bus.valve_open   = (r_state == S_FILL);
  assign bus.capper_on    = (r_state == S_CAP);
  assign bus.batch_done   = (r_state == S_DONE);
  assign bus.alarm        = (r_state == S_FAULT);
  assign bus.bottle_count = r_count;
  assign bus.state        = r_state;

endmodule
